uart_rx_to_mem: RTL

Receive-side counterpart of the matrix transmit path. Deserialises 8N1 UART bytes from the host and writes them, in arrival order, into a ROWS x COLS matrix memory through the memory write port (write / write_address / write_value). Contains its own oversampling receiver clocked directly from clk, plus a load sequencer that fills addresses 0 .. ROWS*COLS-1 and signals completion.

---
 rtl/uart_rx_to_mem_if.sv | 12 +
 rtl/uart_rx_to_mem.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_to_mem_if.sv
// Matrix memory write port: one-cycle strobe with address and byte.
// The loader drives the master side; the memory samples the slave side.
interface uart_rx_to_mem_if #(
  parameter int ADDR_W = 6
);
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (output mem_write, output mem_addr, output mem_wdata);
  modport slave  (input  mem_write, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_rx_to_mem.sv
// 8N1 oversampling UART receiver feeding a sequencer that fills a ROWS x COLS
// matrix memory in arrival order and pulses load_done after the last element.
module uart_rx_to_mem #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int ROWS         = 2,
  parameter int COLS         = 2,
  parameter int ADDR_W       = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_data,
  input  logic                     load_en,
  uart_rx_to_mem_if.master         mem,
  output logic                     busy,
  output logic                     load_done,
  output logic                     frame_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROWS * COLS - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_LOAD,
    L_DONE
  } load_state_t;

  logic              rx_meta;
  logic              rxs;
  rx_state_t         rx_state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              stop_sample;
  logic              byte_valid;
  logic              byte_err;
  load_state_t       load_state;
  logic [ADDR_W-1:0] index;

  // Synchroniser resets to the idle line level so reset release never looks
  // like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make rx_meta -> rxs a true two-stage
      // shift; blocking here would collapse it into a single flop.
      rx_meta <= rx_data;
      rxs     <= rx_meta;
    end
  end

  // Stop-bit verdict is decoded in the sample cycle itself so the loader's
  // registered write lands exactly one clock later.
  assign stop_sample = (rx_state == RX_STOP) && (cnt == CNT_FULL);
  assign byte_valid  = stop_sample &&  rxs;
  assign byte_err    = stop_sample && !rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            rx_state <= RX_START;
            cnt      <= '0;
          end
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxs) begin
              rx_state <= RX_DATA;
              bit_idx  <= '0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt            <= '0;
            shreg[bit_idx] <= rxs;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt      <= '0;
            rx_state <= rxs ? RX_IDLE : RX_WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          // A held-low line (break) must return high before a new frame counts.
          if (rxs) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_state    <= L_IDLE;
      index         <= '0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      frame_error   <= 1'b0;
      mem.mem_write <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      mem.mem_write <= 1'b0;
      load_done     <= 1'b0;
      case (load_state)
        L_IDLE: begin
          if (load_en) begin
            load_state  <= L_LOAD;
            index       <= '0;
            busy        <= 1'b1;
            frame_error <= 1'b0;
          end
        end
        L_LOAD: begin
          if (byte_valid) begin
            mem.mem_write <= 1'b1;
            mem.mem_addr  <= index;
            mem.mem_wdata <= shreg;
            // Index parks on the last element rather than wrapping.
            if (index == LAST_IDX) load_state <= L_DONE;
            else                   index      <= index + 1'b1;
          end else if (byte_err) begin
            frame_error <= 1'b1;
          end
        end
        L_DONE: begin
          load_done  <= 1'b1;
          busy       <= 1'b0;
          load_state <= L_IDLE;
        end
        default: load_state <= L_IDLE;
      endcase
    end
  end

endmodule
